io_bank_cfg: RTL and testbench

//  Parametrised bank of NPINS configurable I/O cells for the FPGA fabric I/O ring.
//  - Per-pin config: tristate mode, registered output path, registered/synchronised input path.
//  - Config arrives over a serial shift chain and is committed atomically to the active config.
//  - Sits between the fabric routing (OUT/TS/IN) and the package pins (PIN).

---
 rtl/io_bank_cfg.sv | 127 ++++++++++++
 tb/tb_io_bank_cfg.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/io_bank_cfg.sv
// Bank of NPINS configurable I/O cells: tristate/registered output path, synchronised input
// path, and a serial config chain committed atomically to the active config.
`timescale 1ns/1ps
module io_bank_cfg #(
  parameter int unsigned NPINS       = 4,
  parameter int unsigned SYNC_STAGES = 1
) (
  input  logic             IOCLK,
  input  logic             RSTN,
  inout  wire  [NPINS-1:0] PIN,
  input  logic [NPINS-1:0] OUT,
  input  logic [NPINS-1:0] TS,
  output logic [NPINS-1:0] IN,
  input  logic             CFG_EN,
  input  logic             CFG_DIN,
  output logic             CFG_DOUT,
  output logic             CFG_DONE,
  output logic             CFG_ERR
);
  localparam int unsigned CFG_W = 4;
  localparam int unsigned LEN   = NPINS * CFG_W;
  localparam int unsigned CNT_W = $clog2(LEN + 2);
  localparam logic [CNT_W-1:0] CNT_LEN = CNT_W'(LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LEN + 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  logic [LEN-1:0]   sr_q, sr_d;
  logic [LEN-1:0]   active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             commit, abort;

  logic [NPINS-1:0] out_q, ts_q;
  logic [NPINS-1:0] sync_q [SYNC_STAGES];
  logic [NPINS-1:0] o_drv, oe;

  always_ff @(posedge IOCLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (CFG_EN)  state_d = SHIFT;
      SHIFT:   if (!CFG_EN) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The frame is judged on the edge where CFG_EN falls, using the count of bits already taken.
  always_comb begin
    sr_d   = CFG_EN ? {sr_q[LEN-2:0], CFG_DIN} : sr_q;
    cnt_d  = '0;
    commit = 1'b0;
    abort  = 1'b0;
    if (CFG_EN) begin
      if (state_q == IDLE)     cnt_d = CNT_W'(1);
      else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
      else                     cnt_d = cnt_q + CNT_W'(1);
    end else if (state_q == SHIFT) begin
      commit = (cnt_q == CNT_LEN);
      abort  = (cnt_q != CNT_LEN);
    end
    active_d = commit ? sr_q : active_q;
    done_d   = commit;
    err_d    = abort;
  end

  assign CFG_DOUT = sr_q[LEN-1];
  assign CFG_DONE = done_q;
  assign CFG_ERR  = err_q;

  always_ff @(posedge IOCLK or negedge RSTN) begin
    if (!RSTN) begin
      out_q <= '0;
      ts_q  <= '0;
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      out_q     <= OUT;
      ts_q      <= TS;
      sync_q[0] <= PIN;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  always_comb begin
    logic [CFG_W-1:0] cfg;
    logic             t;
    cfg   = '0;
    t     = 1'b0;
    o_drv = '0;
    oe    = '0;
    IN    = '0;
    for (int unsigned p = 0; p < NPINS; p++) begin
      cfg      = active_q[CFG_W*p +: CFG_W];
      o_drv[p] = cfg[3] ? out_q[p] : OUT[p];
      t        = cfg[3] ? ts_q[p]  : TS[p];
      case (cfg[1:0])
        2'b00:   oe[p] = 1'b0;
        2'b01:   oe[p] = t;
        default: oe[p] = 1'b1;
      endcase
      IN[p] = cfg[2] ? sync_q[SYNC_STAGES-1][p] : PIN[p];
    end
  end

  for (genvar g = 0; g < NPINS; g++) begin : g_pad
    assign PIN[g] = oe[g] ? o_drv[g] : 1'bz;
  end
endmodule

// File: tb/tb_io_bank_cfg.sv
// Directed bench for io_bank_cfg (NPINS=2, SYNC_STAGES=2): reset, commit, frame errors,
// output/input path latencies and reset during a frame.
`timescale 1ns/1ps
module tb_io_bank_cfg;
  logic       clk;
  logic       rstn;
  logic [1:0] out_v, ts_v, in_v;
  logic       cfg_en, cfg_din, cfg_dout, cfg_done, cfg_err;
  logic [1:0] ext_en, ext_val;
  wire  [1:0] pin;

  int n_assert = 0;
  int n_fail   = 0;

  for (genvar i = 0; i < 2; i++) begin : g_ext
    assign pin[i] = ext_en[i] ? ext_val[i] : 1'bz;
  end

  io_bank_cfg #(.NPINS(2), .SYNC_STAGES(2)) dut (
    .IOCLK(clk), .RSTN(rstn), .PIN(pin), .OUT(out_v), .TS(ts_v), .IN(in_v),
    .CFG_EN(cfg_en), .CFG_DIN(cfg_din), .CFG_DOUT(cfg_dout),
    .CFG_DONE(cfg_done), .CFG_ERR(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Shifts the low n bits of 'bits', MSB first, then drops CFG_EN without clocking.
  task automatic shift_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      cfg_en  = 1'b1;
      cfg_din = bits[i];
      tick();
    end
    cfg_en  = 1'b0;
    cfg_din = 1'b0;
  endtask

  // 1 where the pad reads as a driven 1; with the bench released and OUT=1 a driven pad shows 1.
  function automatic logic [7:0] driven1(input logic [1:0] p);
    return {6'b0, p[1] === 1'b1, p[0] === 1'b1};
  endfunction

  initial begin
    rstn = 1'b0; cfg_en = 1'b0; cfg_din = 1'b0;
    out_v = 2'b00; ts_v = 2'b00; ext_en = 2'b00; ext_val = 2'b00;

    // T1: reset with CFG_EN toggling
    ext_en = 2'b11; ext_val = 2'b10;
    for (int i = 0; i < 4; i++) begin
      cfg_en = ~cfg_en; cfg_din = 1'b1;
      tick();
    end
    chk("rst_in", 8'(in_v), 8'h2);
    chk("rst_done", 8'(cfg_done), 8'h0);
    chk("rst_err", 8'(cfg_err), 8'h0);
    chk("rst_dout", 8'(cfg_dout), 8'h0);
    ext_val = 2'b01; #1;
    chk("rst_in_follow", 8'(in_v), 8'h1);
    ext_en = 2'b00; out_v = 2'b11; ts_v = 2'b11; #1;
    chk("rst_pins_hiz", driven1(pin), 8'h0);
    cfg_en = 1'b0; cfg_din = 1'b0;
    tick();
    rstn = 1'b1;
    tick();

    // T2: commit 1000_0101
    shift_bits(32'h85, 8);
    chk("t2_dout", 8'(cfg_dout), 8'h1);
    tick();
    chk("t2_done", 8'(cfg_done), 8'h1);
    chk("t2_err", 8'(cfg_err), 8'h0);
    tick();
    chk("t2_done_pulse", 8'(cfg_done), 8'h0);
    out_v = 2'b11; ts_v = 2'b01;
    tick();
    chk("t2_pin0_drv_pin1_z", driven1(pin), 8'h1);
    ts_v = 2'b00; #1;
    chk("t2_pin0_ts_off", driven1(pin), 8'h0);

    // T3: short, long and very long frames are rejected
    ts_v = 2'b01;
    shift_bits(32'h0, 7);
    tick();
    chk("t3_short_err", 8'(cfg_err), 8'h1);
    chk("t3_short_done", 8'(cfg_done), 8'h0);
    tick();
    chk("t3_short_err_pulse", 8'(cfg_err), 8'h0);
    chk("t3_short_hold", driven1(pin), 8'h1);
    shift_bits(32'h0, 9);
    tick();
    chk("t3_long_err", 8'(cfg_err), 8'h1);
    tick();
    chk("t3_long_hold", driven1(pin), 8'h1);
    shift_bits(32'h0, 24);
    tick();
    chk("t3_vlong_err", 8'(cfg_err), 8'h1);
    chk("t3_vlong_done", 8'(cfg_done), 8'h0);
    tick();
    chk("t3_vlong_hold", driven1(pin), 8'h1);

    // T4: pin0 OUTREG=1 TSMUX=10, pin1 OUTREG=0 TSMUX=10
    shift_bits(32'h2A, 8);
    tick();
    chk("t4_done", 8'(cfg_done), 8'h1);
    out_v = 2'b00; ts_v = 2'b00;
    tick(); tick();
    chk("t4_low", 8'(pin), 8'h0);
    out_v = 2'b11; #1;
    chk("t4_imm", 8'(pin), 8'h2);
    tick();
    chk("t4_reg_after", 8'(pin), 8'h3);

    // T5: pin0 DORREG=1, pin1 DORREG=0, both pads released
    shift_bits(32'h04, 8);
    tick();
    chk("t5_done", 8'(cfg_done), 8'h1);
    ext_en = 2'b11; ext_val = 2'b00;
    tick(); tick(); tick();
    chk("t5_low", 8'(in_v), 8'h0);
    ext_val = 2'b11; #1;
    chk("t5_same_cycle", 8'(in_v), 8'h2);
    tick();
    chk("t5_after1", 8'(in_v), 8'h2);
    tick();
    chk("t5_after2", 8'(in_v), 8'h3);

    // T6: reset part-way through a frame
    ext_en = 2'b00; out_v = 2'b11;
    shift_bits(32'h2A, 8);
    tick();
    chk("t6_pre_done", 8'(cfg_done), 8'h1);
    chk("t6_pre_drive", driven1(pin), 8'h3);
    tick();
    shift_bits(32'h15, 5);
    cfg_en = 1'b1; cfg_din = 1'b1;
    rstn = 1'b0; #1;
    chk("t6_rst_pins", driven1(pin), 8'h0);
    chk("t6_rst_done", 8'(cfg_done), 8'h0);
    cfg_en = 1'b0; cfg_din = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    chk("t6_no_done", 8'(cfg_done), 8'h0);
    chk("t6_no_err", 8'(cfg_err), 8'h0);
    shift_bits(32'h05, 8);
    tick();
    chk("t6_done", 8'(cfg_done), 8'h1);
    tick();
    chk("t6_done_once", 8'(cfg_done), 8'h0);
    ts_v = 2'b01; #1;
    chk("t6_pin0_drive", driven1(pin), 8'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
